// File: rtl/spi_slave.sv
// SPI slave, all four modes, oversampled by the system clock i_Clk.
// SCK, MOSI and CS are treated as data: synchronized, and SCK edges are found by comparing stages.
module spi_slave #(
    parameter int unsigned SPI_MODE = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_SPI_Clk,
    output logic       o_SPI_MISO,
    input  logic       i_SPI_MOSI,
    input  logic       i_SPI_CS_n
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam logic        CPOL   = 1'((SPI_MODE >> 1) & 1);
    localparam logic        CPHA   = 1'(SPI_MODE & 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

    logic              sck_q1, sck_q2, sck_q3;
    logic              mosi_q1, mosi_q2;
    logic              cs_q1, cs_q2;
    logic [CNT_W-1:0]  bit_cnt;
    logic [BYTE_W-1:0] rx_shift;
    logic              rx_done;
    logic [BYTE_W-1:0] tx_hold;
    logic [BYTE_W-1:0] tx_shift;
    logic              shift_seen;

    logic              cs_active_c;
    logic              lead_c, trail_c;
    logic              sample_c, shift_c, byte_end_c;
    logic [BYTE_W-1:0] tx_load_c;

    // Input synchronizers; SCK idles at CPOL and CS at deasserted so reset release makes no edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sck_q1  <= CPOL;
            sck_q2  <= CPOL;
            sck_q3  <= CPOL;
            mosi_q1 <= 1'b0;
            mosi_q2 <= 1'b0;
            cs_q1   <= 1'b1;
            cs_q2   <= 1'b1;
        end else begin
            sck_q1  <= i_SPI_Clk;
            sck_q2  <= sck_q1;
            sck_q3  <= sck_q2;
            mosi_q1 <= i_SPI_MOSI;
            mosi_q2 <= mosi_q1;
            cs_q1   <= i_SPI_CS_n;
            cs_q2   <= cs_q1;
        end
    end

    // Edge classification: leading leaves CPOL, trailing returns to it; CPHA picks which one samples.
    always_comb begin
        cs_active_c = ~cs_q2;
        lead_c      = (sck_q2 != CPOL) && (sck_q3 == CPOL);
        trail_c     = (sck_q2 == CPOL) && (sck_q3 != CPOL);
        sample_c    = cs_active_c && (CPHA ? trail_c : lead_c);
        shift_c     = cs_active_c && (CPHA ? lead_c : trail_c);
        byte_end_c  = sample_c && (bit_cnt == LAST_BIT);
        tx_load_c   = i_TX_DV ? i_TX_Byte : tx_hold;
    end

    // Receive path: shift MOSI in MSB first, publish the byte one cycle after the 8th sample.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            rx_done   <= 1'b0;
            o_RX_DV   <= 1'b0;
            o_RX_Byte <= '0;
        end else begin
            rx_done <= byte_end_c;
            o_RX_DV <= rx_done;
            if (rx_done) begin
                o_RX_Byte <= rx_shift;
            end
            if (!cs_active_c) begin
                bit_cnt <= '0;
            end else if (sample_c) begin
                rx_shift <= {rx_shift[BYTE_W-2:0], mosi_q2};
                bit_cnt  <= CNT_W'(bit_cnt + 1'b1);
            end
        end
    end

    // Transmit path: holding register plus shift register; the first shift edge of a byte only
    // marks the byte as started, so the MSB loaded at the byte boundary is not dropped.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_hold    <= '0;
            tx_shift   <= '0;
            shift_seen <= 1'b0;
        end else begin
            if (i_TX_DV) begin
                tx_hold <= i_TX_Byte;
            end
            if (!cs_active_c) begin
                tx_shift   <= tx_load_c;
                shift_seen <= 1'b0;
            end else if (byte_end_c) begin
                tx_shift   <= tx_load_c;
                shift_seen <= 1'b0;
            end else if (shift_c) begin
                shift_seen <= 1'b1;
                if (bit_cnt != '0) begin
                    tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                end
            end else if (i_TX_DV && (bit_cnt == '0) && !shift_seen) begin
                tx_shift <= i_TX_Byte;
            end
        end
    end

    // MISO released whenever the chip-select pin is high, reset included.
    assign o_SPI_MISO = i_SPI_CS_n ? 1'bz : tx_shift[BYTE_W-1];

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, a byte-level master, and a byte-level model.
module tb_spi_slave;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       mosi;
    logic [3:0] sck;
    logic [3:0] cs_n;
    logic       rx_dv   [4];
    logic [7:0] rx_byte [4];
    wire        miso    [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wire miso_pin;
        pullup pu (miso_pin);
        spi_slave #(.SPI_MODE(g)) dut (
            .i_Clk      (clk),
            .i_Rst_L    (rst_n),
            .o_RX_DV    (rx_dv[g]),
            .o_RX_Byte  (rx_byte[g]),
            .i_TX_DV    (tx_dv),
            .i_TX_Byte  (tx_byte),
            .i_SPI_Clk  (sck[g]),
            .o_SPI_MISO (miso_pin),
            .i_SPI_MOSI (mosi),
            .i_SPI_CS_n (cs_n[g])
        );
        assign miso[g] = miso_pin;
    end

    int         checks = 0;
    int         fails  = 0;
    int         cyc    = 0;
    int         cur    = 0;
    int         dv_cnt [4] = '{0, 0, 0, 0};
    int         last_dv_cyc = 0;
    int         last_samp_cyc = 0;
    logic [7:0] rxq [$];

    logic       dv_pend = 1'b0;
    logic [7:0] dv_val  = 8'h00;
    logic [7:0] f_mosi [8];
    logic [7:0] f_miso [8];

    logic [7:0] model_hold = 8'h00;
    logic [7:0] model_last_rx [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int         exp_dv_total [4] = '{0, 0, 0, 0};

    typedef struct {
        int         mode;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;
    vec_t vt [6];

    // Cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Receive monitor, sampled on the falling edge.
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rx_dv[m]) begin
                dv_cnt[m] <= dv_cnt[m] + 1;
                if (m == cur) begin
                    rxq.push_back(rx_byte[m]);
                    last_dv_cyc <= cyc;
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tx_load(input logic [7:0] v);
        @(negedge clk);
        tx_dv   = 1'b1;
        tx_byte = v;
        @(negedge clk);
        tx_dv = 1'b0;
        model_hold = v;
    endtask

    task automatic wait_half();
        for (int k = 0; k < HALF; k++) begin
            if (k == 0 && dv_pend) begin
                tx_dv   = 1'b1;
                tx_byte = dv_val;
                dv_pend = 1'b0;
            end
            @(negedge clk);
            tx_dv = 1'b0;
        end
    endtask

    // Master side of one byte: sends nbits of mo MSB first and returns what it sampled on MISO.
    task automatic spi_bits(input int m, input logic [7:0] mo, input int nbits, input int dv_pos,
                            output logic [7:0] mi);
        logic cpol;
        logic cpha;
        cpol = m[1];
        cpha = m[0];
        mi = 8'h00;
        for (int p = 0; p < nbits; p++) begin
            if (p == dv_pos) dv_pend = 1'b1;
            if (!cpha) begin
                mosi = mo[3'(7 - p)];
                wait_half();
                mi[3'(7 - p)] = miso[2'(m)];
                sck[2'(m)] = ~cpol;
                if (p == 7) last_samp_cyc = cyc;
                wait_half();
                sck[2'(m)] = cpol;
            end else begin
                sck[2'(m)] = ~cpol;
                mosi = mo[3'(7 - p)];
                wait_half();
                mi[3'(7 - p)] = miso[2'(m)];
                sck[2'(m)] = cpol;
                if (p == 7) last_samp_cyc = cyc;
                wait_half();
            end
        end
    endtask

    // One CS frame of nbytes from f_mosi; a nonzero abort_bits truncates the last byte.
    task automatic run_frame(input int m, input int nbytes, input int dv_byte, input int dv_pos,
                             input int abort_bits);
        logic [7:0] b;
        cs_n[2'(m)] = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int j = 0; j < nbytes; j++) begin
            spi_bits(m, f_mosi[j], (j == nbytes - 1 && abort_bits > 0) ? abort_bits : 8,
                     (j == dv_byte) ? dv_pos : -1, b);
            f_miso[j] = b;
        end
        repeat (2 * HALF) @(negedge clk);
        cs_n[2'(m)] = 1'b1;
        dv_pend = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    function automatic logic [31:0] rxq_at(input int j);
        return (j < rxq.size()) ? 32'(rxq[j]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int         base;
        int         nb, abort_bits, complete, dvb, dvp;
        logic [7:0] dvv, cur_tx, b;

        vt[0] = '{0, 8'h55, 8'hAA, 8'hAA, 8'h55};
        vt[1] = '{1, 8'h55, 8'hAA, 8'hAA, 8'h55};
        vt[2] = '{2, 8'h55, 8'hAA, 8'hAA, 8'h55};
        vt[3] = '{3, 8'h55, 8'hAA, 8'hAA, 8'h55};
        vt[4] = '{0, 8'h00, 8'hFF, 8'hFF, 8'h00};
        vt[5] = '{3, 8'h81, 8'h7E, 8'h7E, 8'h81};

        rst_n   = 1'b1;
        tx_dv   = 1'b0;
        tx_byte = 8'h00;
        mosi    = 1'b0;
        sck     = 4'b1100;
        cs_n    = 4'b1111;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state and MISO behaviour while reset is held.
        for (int m = 0; m < 4; m++) begin
            chk("reset_rx_dv", 32'(rx_dv[m]), 32'h0);
            chk("reset_rx_byte", 32'(rx_byte[m]), 32'h00);
            chk("reset_miso_cs_high_z", 32'(miso[m]), 32'h1);
        end
        cs_n[0] = 1'b0;
        @(negedge clk);
        chk("reset_miso_cs_low", 32'(miso[0]), 32'h0);
        cs_n[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single-byte vectors in every mode.
        for (int i = 0; i < 6; i++) begin
            cur = vt[i].mode;
            tx_load(vt[i].tx);
            f_mosi[0] = vt[i].mo;
            rxq.delete();
            base = dv_cnt[cur];
            run_frame(cur, 1, -1, 0, 0);
            chk("vec_pulses", 32'(dv_cnt[cur] - base), 32'd1);
            chk("vec_rx_queue", rxq_at(0), 32'(vt[i].exp_rx));
            chk("vec_rx_byte", 32'(rx_byte[cur]), 32'(vt[i].exp_rx));
            chk("vec_miso", 32'(f_miso[0]), 32'(vt[i].exp_miso));
            chk("vec_dv_latency", 32'(last_dv_cyc - last_samp_cyc), 32'd4);
            model_last_rx[cur] = vt[i].exp_rx;
            exp_dv_total[cur] += 1;
        end

        // Two bytes back to back in one frame, TX not reloaded.
        cur = 0;
        tx_load(8'h33);
        f_mosi[0] = 8'h99;
        f_mosi[1] = 8'h66;
        rxq.delete();
        base = dv_cnt[0];
        run_frame(0, 2, -1, 0, 0);
        chk("two_byte_pulses", 32'(dv_cnt[0] - base), 32'd2);
        chk("two_byte_rx0", rxq_at(0), 32'h99);
        chk("two_byte_rx1", rxq_at(1), 32'h66);
        chk("two_byte_miso0", 32'(f_miso[0]), 32'h33);
        chk("two_byte_miso1", 32'(f_miso[1]), 32'h33);
        model_last_rx[0] = 8'h66;
        exp_dv_total[0] += 2;

        // Aborted byte, SCK activity with CS high, then a full byte.
        rxq.delete();
        base = dv_cnt[0];
        f_mosi[0] = 8'h5A;
        run_frame(0, 1, -1, 0, 5);
        chk("abort_no_pulse", 32'(dv_cnt[0] - base), 32'd0);
        chk("abort_rx_held", 32'(rx_byte[0]), 32'h66);
        spi_bits(0, 8'hFF, 8, -1, b);
        repeat (2 * HALF) @(negedge clk);
        chk("cs_high_sck_ignored", 32'(dv_cnt[0] - base), 32'd0);
        f_mosi[0] = 8'h77;
        run_frame(0, 1, -1, 0, 0);
        chk("after_abort_pulses", 32'(dv_cnt[0] - base), 32'd1);
        chk("after_abort_rx", 32'(rx_byte[0]), 32'h77);
        model_last_rx[0] = 8'h77;
        exp_dv_total[0] += 1;

        // TX reload in the middle of a byte only affects the next byte.
        tx_load(8'h0F);
        dv_val = 8'hF0;
        f_mosi[0] = 8'h12;
        f_mosi[1] = 8'h34;
        base = dv_cnt[0];
        run_frame(0, 2, 0, 3, 0);
        model_hold = 8'hF0;
        chk("mid_dv_miso0", 32'(f_miso[0]), 32'h0F);
        chk("mid_dv_miso1", 32'(f_miso[1]), 32'hF0);
        chk("mid_dv_pulses", 32'(dv_cnt[0] - base), 32'd2);
        model_last_rx[0] = 8'h34;
        exp_dv_total[0] += 2;

        // MISO released with CS high even when the driven bit would be 0.
        tx_load(8'h00);
        @(negedge clk);
        chk("miso_z_cs_high", 32'(miso[0]), 32'h1);

        // Reset in the middle of a byte.
        base = dv_cnt[0];
        cs_n[0] = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(0, 8'hA5, 4, -1, b);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_rx_byte", 32'(rx_byte[0]), 32'h00);
        chk("midreset_rx_dv", 32'(rx_dv[0]), 32'h0);
        chk("midreset_miso_cs_low", 32'(miso[0]), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_hold = 8'h00;
        for (int m = 0; m < 4; m++) model_last_rx[m] = 8'h00;
        repeat (2) @(negedge clk);
        cs_n[0] = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        chk("midreset_no_pulse", 32'(dv_cnt[0] - base), 32'd0);
        f_mosi[0] = 8'hC3;
        rxq.delete();
        run_frame(0, 1, -1, 0, 0);
        chk("post_reset_pulses", 32'(dv_cnt[0] - base), 32'd1);
        chk("post_reset_rx", 32'(rx_byte[0]), 32'hC3);
        chk("post_reset_miso", 32'(f_miso[0]), 32'h00);
        model_last_rx[0] = 8'hC3;
        exp_dv_total[0] += 1;

        // Random frames against the byte-level model.
        for (int m = 0; m < 4; m++) begin
            cur = m;
            for (int f = 0; f < 10; f++) begin
                if ($urandom_range(1, 0) == 1) tx_load(8'($urandom));
                nb         = int'($urandom_range(3, 1));
                abort_bits = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 1)) : 0;
                complete   = (abort_bits > 0) ? nb - 1 : nb;
                dvb        = (complete > 0 && $urandom_range(1, 0) == 1) ?
                             int'($urandom_range(complete - 1, 0)) : -1;
                dvp        = int'($urandom_range(7, 1));
                dvv        = 8'($urandom);
                dv_val     = dvv;
                for (int j = 0; j < nb; j++) f_mosi[j] = 8'($urandom);
                rxq.delete();
                base   = dv_cnt[m];
                cur_tx = model_hold;
                run_frame(m, nb, dvb, dvp, abort_bits);
                chk("rand_pulses", 32'(dv_cnt[m] - base), 32'(complete));
                for (int j = 0; j < complete; j++) begin
                    chk("rand_rx", rxq_at(j), 32'(f_mosi[j]));
                    chk("rand_miso", 32'(f_miso[j]), 32'(cur_tx));
                    if (j == dvb) cur_tx = dvv;
                end
                if (dvb >= 0) model_hold = dvv;
                if (complete > 0) model_last_rx[m] = f_mosi[complete - 1];
                chk("rand_rx_byte_held", 32'(rx_byte[m]), 32'(model_last_rx[m]));
                exp_dv_total[m] += complete;
            end
        end

        // Every instance produced exactly the pulses it was expected to.
        for (int m = 0; m < 4; m++) begin
            chk("total_pulses", 32'(dv_cnt[m]), 32'(exp_dv_total[m]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SPI_MODE, default 0, SPI mode 0-3: CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
REQ-002 i_Clk  input  1  system clock; the only clock, all logic on its rising edge.
REQ-003 i_Rst_L  input  1  asynchronous, active-low reset.
REQ-004 o_RX_DV  output  1  one-cycle pulse when a received byte is valid.
REQ-005 o_RX_Byte  output  8  last complete byte received on MOSI, MSB first.
REQ-006 i_TX_DV  input  1  one-cycle strobe loading i_TX_Byte for transmission.
REQ-007 i_TX_Byte  input  8  byte to send on MISO, MSB first.
REQ-008 i_SPI_Clk  input  1  SPI clock from master, treated as data and sampled by i_Clk.
REQ-009 o_SPI_MISO  output  1  serial data to master; high-impedance while i_SPI_CS_n = 1.
REQ-010 i_SPI_MOSI  input  1  serial data from master.
REQ-011 i_SPI_CS_n  input  1  active-low chip select.

Function
REQ-012 i_SPI_Clk, i_SPI_MOSI and i_SPI_CS_n SHALL each pass through a 2-flop synchronizer; SCK edges are detected by comparing the 2nd stage against a 3rd delayed stage.
REQ-013 Operation SHALL require i_Clk >= 4x SPI clock frequency; no other clock domain exists.
REQ-014 Leading SCK edge is the first edge away from CPOL, trailing edge the return to CPOL; the sampling edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1, and the shift edge is the other one.
REQ-015 On each sampling edge with CS asserted, the synchronized MOSI SHALL shift into the RX shift register LSB side (MSB received first) and the 3-bit bit counter SHALL increment.
REQ-016 On the 8th sampling edge, the full byte SHALL load o_RX_Byte and o_RX_DV SHALL be 1 for exactly one i_Clk cycle, 3 i_Clk cycles after the i_Clk edge that first captures the new SCK level; the counter wraps to 0.
REQ-017 o_RX_Byte SHALL hold its value until the next complete byte.
REQ-018 i_TX_DV=1 SHALL copy i_TX_Byte into a TX holding register; the last loaded value is retransmitted on every byte until reloaded.
REQ-019 The TX shift register SHALL load from the holding register on CS assertion, at each byte boundary (8th sampling edge), and on i_TX_DV while the bit counter is 0 and no shift edge of the current byte has occurred.
REQ-020 An i_TX_DV arriving mid-byte SHALL NOT disturb the byte in progress; the new value goes out on the next byte.
REQ-021 MISO SHALL present the shift-register MSB; each shift edge advances to the next bit.
REQ-022 CPHA=0: the first bit is driven before the first SCK edge, and the shift edge after the 8th sample exposes the MSB of the next byte.
REQ-023 CPHA=1: the first leading edge of a byte is a shift edge and does not drop a bit; bit 7 is driven from that edge.
REQ-024 Synchronized CS deassertion SHALL clear the bit counter and discard a partial RX byte with no o_RX_DV; o_RX_Byte is unchanged.
REQ-025 SCK edges while CS is deasserted SHALL be ignored.
REQ-026 Multiple consecutive bytes within one CS frame SHALL be supported without gaps, each producing its own o_RX_DV.

Reset
REQ-027 While i_Rst_L=0, independent of i_Clk: o_RX_DV=0, o_RX_Byte=0x00, TX holding and shift registers 0x00, bit counter 0.
REQ-028 While i_Rst_L=0, SCK synchronizer stages are set to CPOL and CS stages to 1, so no edge is detected on reset release.
REQ-029 While i_Rst_L=0, o_SPI_MISO follows the pin state of i_SPI_CS_n.
REQ-030 Reset asserted mid-byte SHALL abort the byte with no o_RX_DV pulse; after release the next full byte is received normally.

Verification
REQ-031 Mode 0, TX_DV with 0x55, then CS low and MOSI 0xAA -> one o_RX_DV, o_RX_Byte=0xAA; MISO samples at rising SCK read 0x55.
REQ-032 One CS frame carrying 0x99 then 0x66 -> two o_RX_DV pulses, bytes in order; TX 0x33 is sent in both bytes when not reloaded.
REQ-033 CS raised after 5 bits, then a full 0x77 frame -> exactly one pulse, o_RX_Byte=0x77.
REQ-034 TX_DV 0xF0 during bit 3 of a byte sending 0x0F -> that byte reads 0x0F at the master, the next reads 0xF0.
REQ-035 CS high -> MISO Z; i_Rst_L low mid-byte -> o_RX_Byte=0x00, no pulse, then a clean byte 0xC3 after release.
REQ-036 Modes 1, 2 and 3 repeat REQ-031 -> identical RX/TX byte results.
